// File: rtl/regfile_bank_pkg.sv
// Shared constants and state encoding for the integer register bank.
// Used by regfile_bank and regfile_clear_fsm.
package regfile_bank_pkg;

    localparam int REGFILE_NUM_REGS = 32;
    localparam int REGFILE_ADDR_W   = 5;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential bulk-clear engine: walks words 1..31, one word per cycle.
// Flags writes that arrive while a clear is running as dropped.
module regfile_clear_fsm
    import regfile_bank_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_req,
    input  logic                      we,
    input  logic [REGFILE_ADDR_W-1:0] waddr,
    output logic                      busy,
    output logic                      wr_drop,
    output logic                      clr_we,
    output logic [REGFILE_ADDR_W-1:0] clr_addr
);

    localparam logic [REGFILE_ADDR_W-1:0] LAST_ADDR =
        REGFILE_ADDR_W'(REGFILE_NUM_REGS - 1);

    rf_state_e                 state_q;
    logic [REGFILE_ADDR_W-1:0] clr_cnt_q;
    logic                      busy_q;
    logic                      wr_drop_q;

    // State, clear pointer and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_IDLE;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= (state_q == RF_CLEAR) && we && (waddr != '0);
            unique case (state_q)
                RF_IDLE: begin
                    if (clr_req) begin
                        state_q   <= RF_CLEAR;
                        clr_cnt_q <= REGFILE_ADDR_W'(1);
                        busy_q    <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= RF_IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + REGFILE_ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign wr_drop  = wr_drop_q;
    assign clr_we   = (state_q == RF_CLEAR);
    assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/regfile_bank.sv
// 32 x WIDTH register storage with x0 hardwired to zero and bulk clear.
// Optional same-cycle write bypass on dout: REGFILE_WRITE_BYPASS_EN.
module regfile_bank
    import regfile_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [REGFILE_ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      clr_req,
    output logic                      busy,
    output logic                      wr_drop,
    output logic [WIDTH*32-1:0]       dout
);

    if (NUM_REGS != REGFILE_NUM_REGS) begin : g_bad_num_regs
        $error("regfile_bank: NUM_REGS must be 32");
    end

    logic                      clr_we;
    logic [REGFILE_ADDR_W-1:0] clr_addr;
    logic                      wr_en;

    regfile_clear_fsm u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .we       (we),
        .waddr    (waddr),
        .busy     (busy),
        .wr_drop  (wr_drop),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Writes only land while idle; x0 is never written
    assign wr_en = we && (waddr != '0) && !busy;

    assign dout[WIDTH-1:0] = '0;

    for (genvar i = 1; i < REGFILE_NUM_REGS; i++) begin : g_word
        localparam logic [REGFILE_ADDR_W-1:0] ADDR = REGFILE_ADDR_W'(i);
        logic [WIDTH-1:0] word_q;

        // One storage word: clear engine wins, otherwise the write port
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (clr_we && (clr_addr == ADDR)) begin
                word_q <= '0;
            end else if (wr_en && (waddr == ADDR)) begin
                word_q <= wdata;
            end
        end

`ifdef REGFILE_WRITE_BYPASS_EN
        assign dout[WIDTH*(i+1)-1 -: WIDTH] =
            (wr_en && (waddr == ADDR)) ? wdata : word_q;
`else
        assign dout[WIDTH*(i+1)-1 -: WIDTH] = word_q;
`endif
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Scoreboard testbench for regfile_bank: directed scenarios plus random traffic.
// Expected outputs come from an array model and are checked by a separate monitor.
module tb_regfile_bank;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          clr_req;
    logic          busy;
    logic          wr_drop;
    logic [1023:0] dout;

    regfile_bank #(.WIDTH(32), .NUM_REGS(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_drop (wr_drop),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1023:0] d;
        logic          b;
        logic          w;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: register contents, remaining clear cycles, drop flag
    logic [31:0] m [32];
    int          clr_left;
    logic        drop_m;

    function automatic logic [1023:0] model_bus();
        logic [1023:0] e;
        for (int i = 0; i < 32; i++) e[32*i +: 32] = (i == 0) ? 32'd0 : m[i];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = '0;
        clr_left = 0;
        drop_m   = 1'b0;
    endtask

    task automatic chk_bus(input string nm, input logic [1023:0] a, input logic [1023:0] e);
        total++;
        if (a !== e) begin
            bad++;
            for (int i = 0; i < 32; i++) begin
                if (a[32*i +: 32] !== e[32*i +: 32]) begin
                    $display("FAIL %s word%0d got=%h want=%h", nm, i, a[32*i +: 32], e[32*i +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic chk_bit(input string nm, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, a, e);
        end
    endtask

    // One clock cycle of stimulus: drive, push expectation, advance model
    task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d, input logic c);
        exp_t e;
        logic bsy;
        @(negedge clk);
        we = w; waddr = a; wdata = d; clr_req = c;
        bsy = (clr_left > 0);
        e.d = model_bus();
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!bsy && w && a != 0) e.d[32*a +: 32] = d;
`endif
        e.b = bsy;
        e.w = drop_m;
        q.push_back(e);
        drop_m = bsy && w && (a != 0);
        if (bsy) begin
            m[32 - clr_left] = '0;
            clr_left--;
        end else begin
            if (w && a != 0) m[a] = d;
            if (c) clr_left = 31;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    // Asynchronous reset between clock edges, checked immediately
    task automatic do_reset();
        @(posedge clk);
        #2;
        we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_bus("reset_dout", dout, '0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_drop", wr_drop, 1'b0);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compares every presented output against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk_bus("dout", dout, e.d);
                chk_bit("busy", busy, e.b);
                chk_bit("wr_drop", wr_drop, e.w);
            end
        end
    end

    initial begin
        rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_bus("init_dout", dout, '0);
        chk_bit("init_busy", busy, 1'b0);
        chk_bit("init_drop", wr_drop, 1'b0);
        #1 rst_n = 1'b1;

        // Basic write and x0 write
        cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        idle(2);
        total++;
        if (dout[191:160] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL word5_direct got=%h want=%h", dout[191:160], 32'hDEAD_BEEF);
        end

        // Preload then full clear
        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'hA5A5_0000 + i, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1);
        idle(33);

        // Preload, clear, write at clear cycle 10, second request at 12
        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), $urandom, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1);
        idle(9);
        cyc(1'b1, 5'd3, 32'd1, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1);
        idle(22);

        // Simultaneous write and clear request
        cyc(1'b1, 5'd31, 32'd7, 1'b1);
        idle(33);

        // Bypass / no-bypass observation on word 9
        cyc(1'b1, 5'd9, 32'h1234, 1'b0);
        idle(1);

        // Reset in the middle of a clear
        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), $urandom, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1);
        idle(7);
        do_reset();
        idle(3);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)),
                $urandom, ($urandom_range(0, 99) < 3));
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        idle(34);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #5;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
